// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath: FETCH/DECODE/EXEC/MEM/WB
// with a memory ready handshake, illegal-opcode detection and a retired-instruction counter.
module multicycle_control #(
    parameter int PC_INC = 2,
    parameter int CNT_W  = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       OPCODE,
    input  logic             MemReady,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IrWrite,
    output logic             PcWrite,
    output logic             PcWriteCond,
    output logic             PcSource,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       AluOp,
    output logic             Shift,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             Illegal,
    output logic             InstrDone,
    output logic [CNT_W-1:0] RetiredCount,
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SHF  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b1100;
    localparam logic [3:0] OP_SW   = 4'b1101;
    localparam logic [3:0] OP_BEQ  = 4'b1111;

    state_t state, next_state;
    logic   is_rtype, is_itype, is_mem, legal;

    // The instruction register is loaded at the end of FETCH, so OPCODE is stable from DECODE on.
    assign is_rtype = (OPCODE == OP_ADD) || (OPCODE == OP_SUB) || (OPCODE == OP_SHF);
    assign is_itype = (OPCODE == 4'b1001) || (OPCODE == 4'b1010) || (OPCODE == 4'b1011);
    assign is_mem   = (OPCODE == OP_LW) || (OPCODE == OP_SW);
    assign legal    = is_rtype || is_itype || is_mem || (OPCODE == OP_BEQ);

    assign State = state;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= FETCH;
            RetiredCount <= '0;
        end else begin
            state <= next_state;
            if (InstrDone)
                RetiredCount <= RetiredCount + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:  if (MemReady) next_state = DECODE;
            DECODE: next_state = legal ? EXEC : FETCH;
            EXEC: begin
                if (is_mem)                 next_state = MEM;
                else if (OPCODE == OP_BEQ)  next_state = FETCH;
                else                        next_state = WB;
            end
            MEM: begin
                if (OPCODE == OP_LW)        next_state = MemReady ? WB : MEM;
                else if (OPCODE == OP_SW)   next_state = MemReady ? FETCH : MEM;
                else                        next_state = FETCH;
            end
            WB:      next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IrWrite     = 1'b0;
        PcWrite     = 1'b0;
        PcWriteCond = 1'b0;
        PcSource    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        AluOp       = 2'b00;
        Shift       = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        Illegal     = 1'b0;
        InstrDone   = 1'b0;
        unique case (state)
            FETCH: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                IrWrite = MemReady;
                PcWrite = MemReady;
            end
            DECODE: begin
                AluSrcB = 2'b11;
                Illegal = !legal;
            end
            EXEC: begin
                AluSrcA = 1'b1;
                if (OPCODE == OP_SHF) begin
                    AluOp = 2'b10;
                    Shift = 1'b1;
                end else if (is_rtype) begin
                    AluOp = 2'b10;
                end else if (is_itype) begin
                    AluSrcB = 2'b10;
                    AluOp   = 2'b11;
                end else if (is_mem) begin
                    AluSrcB = 2'b10;
                end else if (OPCODE == OP_BEQ) begin
                    AluOp       = 2'b01;
                    PcWriteCond = 1'b1;
                    PcSource    = 1'b1;
                    InstrDone   = 1'b1;
                end
            end
            MEM: begin
                IorD = 1'b1;
                if (OPCODE == OP_LW) begin
                    MemRead = 1'b1;
                end else if (OPCODE == OP_SW) begin
                    MemWrite  = 1'b1;
                    InstrDone = MemReady;
                end
            end
            WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                RegDst    = is_rtype;
                MemToReg  = (OPCODE == OP_LW);
            end
            default: ;
        endcase
        // Reset abandons the instruction in flight: no strobe or write may escape this cycle.
        if (Reset) begin
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IrWrite     = 1'b0;
            PcWrite     = 1'b0;
            PcWriteCond = 1'b0;
            RegWrite    = 1'b0;
            Illegal     = 1'b0;
            InstrDone   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second 4-bit-counter instance shares all stimulus
// so counter wrap-around can be reached in a few dozen instructions.
module tb_multicycle_control;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  OPCODE;
    logic        MemReady;

    logic        IorD, MemRead, MemWrite, IrWrite, PcWrite, PcWriteCond, PcSource, AluSrcA;
    logic [1:0]  AluSrcB, AluOp;
    logic        Shift, RegDst, MemToReg, RegWrite, Illegal, InstrDone;
    logic [15:0] RetiredCount;
    logic [2:0]  State;

    logic        w_IorD, w_MemRead, w_MemWrite, w_IrWrite, w_PcWrite, w_PcWriteCond;
    logic        w_PcSource, w_AluSrcA, w_Shift, w_RegDst, w_MemToReg, w_RegWrite;
    logic        w_Illegal, w_InstrDone;
    logic [1:0]  w_AluSrcB, w_AluOp;
    logic [3:0]  w_RetiredCount;
    logic [2:0]  w_State;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    multicycle_control dut (
        .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IrWrite(IrWrite),
        .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .PcSource(PcSource),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .Shift(Shift),
        .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .Illegal(Illegal),
        .InstrDone(InstrDone), .RetiredCount(RetiredCount), .State(State)
    );

    multicycle_control #(.CNT_W(4)) dut_w (
        .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .MemReady(MemReady),
        .IorD(w_IorD), .MemRead(w_MemRead), .MemWrite(w_MemWrite), .IrWrite(w_IrWrite),
        .PcWrite(w_PcWrite), .PcWriteCond(w_PcWriteCond), .PcSource(w_PcSource),
        .AluSrcA(w_AluSrcA), .AluSrcB(w_AluSrcB), .AluOp(w_AluOp), .Shift(w_Shift),
        .RegDst(w_RegDst), .MemToReg(w_MemToReg), .RegWrite(w_RegWrite),
        .Illegal(w_Illegal), .InstrDone(w_InstrDone), .RetiredCount(w_RetiredCount),
        .State(w_State)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 2 time units past the rising edge.
    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic run_beq();
        OPCODE   = 4'b1111;
        MemReady = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        Reset    = 1'b1;
        OPCODE   = 4'b0001;
        MemReady = 1'b1;

        // Reset held two cycles; strobes are forced low throughout.
        tick();
        check("rst_state", State, 3'd0);
        check("rst_memread", MemRead, 1'b0);
        check("rst_irwrite", IrWrite, 1'b0);
        check("rst_count", RetiredCount, 16'd0);
        tick();
        Reset = 1'b0;
        #1;

        // R-type SUB: 0,1,2,4,0.
        check("r_fetch_state", State, 3'd0);
        check("r_fetch_memread", MemRead, 1'b1);
        check("r_fetch_irwrite", IrWrite, 1'b1);
        check("r_fetch_pcwrite", PcWrite, 1'b1);
        check("r_fetch_alusrcb", AluSrcB, 2'b01);
        tick();
        check("r_dec_state", State, 3'd1);
        check("r_dec_alusrcb", AluSrcB, 2'b11);
        check("r_dec_illegal", Illegal, 1'b0);
        check("r_dec_regwrite", RegWrite, 1'b0);
        tick();
        check("r_exec_state", State, 3'd2);
        check("r_exec_alusrca", AluSrcA, 1'b1);
        check("r_exec_aluop", AluOp, 2'b10);
        check("r_exec_regwrite", RegWrite, 1'b0);
        check("r_exec_done", InstrDone, 1'b0);
        tick();
        check("r_wb_state", State, 3'd4);
        check("r_wb_regwrite", RegWrite, 1'b1);
        check("r_wb_regdst", RegDst, 1'b1);
        check("r_wb_memtoreg", MemToReg, 1'b0);
        check("r_wb_done", InstrDone, 1'b1);
        tick();
        check("r_end_state", State, 3'd0);
        check("r_end_done", InstrDone, 1'b0);
        check("r_end_count", RetiredCount, 16'd1);

        // LW with three wait cycles in MEM: 8 cycles total.
        OPCODE = 4'b1100;
        tick();
        check("lw_dec_state", State, 3'd1);
        tick();
        check("lw_exec_state", State, 3'd2);
        check("lw_exec_alusrcb", AluSrcB, 2'b10);
        check("lw_exec_aluop", AluOp, 2'b00);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_mem_wait_state", State, 3'd3);
            check("lw_mem_wait_memread", MemRead, 1'b1);
            check("lw_mem_wait_iord", IorD, 1'b1);
        end
        tick();
        check("lw_mem_stall_state", State, 3'd3);
        MemReady = 1'b1;
        #1;
        check("lw_mem_ready_memread", MemRead, 1'b1);
        check("lw_mem_ready_iord", IorD, 1'b1);
        check("lw_mem_ready_done", InstrDone, 1'b0);
        tick();
        check("lw_wb_state", State, 3'd4);
        check("lw_wb_memtoreg", MemToReg, 1'b1);
        check("lw_wb_regdst", RegDst, 1'b0);
        check("lw_wb_regwrite", RegWrite, 1'b1);
        tick();
        check("lw_end_state", State, 3'd0);
        check("lw_end_count", RetiredCount, 16'd2);

        // SW with no wait: 4 cycles, one MemWrite cycle, never RegWrite.
        OPCODE = 4'b1101;
        check("sw_fetch_regwrite", RegWrite, 1'b0);
        tick();
        check("sw_dec_regwrite", RegWrite, 1'b0);
        tick();
        check("sw_exec_memwrite", MemWrite, 1'b0);
        check("sw_exec_regwrite", RegWrite, 1'b0);
        tick();
        check("sw_mem_state", State, 3'd3);
        check("sw_mem_memwrite", MemWrite, 1'b1);
        check("sw_mem_memread", MemRead, 1'b0);
        check("sw_mem_done", InstrDone, 1'b1);
        check("sw_mem_regwrite", RegWrite, 1'b0);
        tick();
        check("sw_end_state", State, 3'd0);
        check("sw_end_memwrite", MemWrite, 1'b0);
        check("sw_end_count", RetiredCount, 16'd3);

        // BEQ: 3 cycles, retires from EXEC.
        OPCODE = 4'b1111;
        tick();
        tick();
        check("beq_exec_state", State, 3'd2);
        check("beq_exec_pcwritecond", PcWriteCond, 1'b1);
        check("beq_exec_pcsource", PcSource, 1'b1);
        check("beq_exec_aluop", AluOp, 2'b01);
        check("beq_exec_alusrcb", AluSrcB, 2'b00);
        check("beq_exec_done", InstrDone, 1'b1);
        tick();
        check("beq_end_state", State, 3'd0);
        check("beq_end_count", RetiredCount, 16'd4);

        // Shift and I-type sanity in EXEC/WB.
        OPCODE = 4'b0010;
        repeat (2) tick();
        check("shf_exec_shift", Shift, 1'b1);
        check("shf_exec_aluop", AluOp, 2'b10);
        tick();
        check("shf_wb_regdst", RegDst, 1'b1);
        tick();
        OPCODE = 4'b1010;
        repeat (2) tick();
        check("imm_exec_alusrcb", AluSrcB, 2'b10);
        check("imm_exec_aluop", AluOp, 2'b11);
        check("imm_exec_shift", Shift, 1'b0);
        tick();
        check("imm_wb_regdst", RegDst, 1'b0);
        check("imm_wb_memtoreg", MemToReg, 1'b0);
        tick();
        check("imm_end_count", RetiredCount, 16'd6);

        // Illegal opcode: pulse in DECODE, back to FETCH, no retire.
        OPCODE = 4'b0110;
        tick();
        check("ill_dec_state", State, 3'd1);
        check("ill_dec_illegal", Illegal, 1'b1);
        check("ill_dec_done", InstrDone, 1'b0);
        tick();
        check("ill_end_state", State, 3'd0);
        check("ill_end_illegal", Illegal, 1'b0);
        check("ill_end_count", RetiredCount, 16'd6);

        // Reset during SW MEM with MemReady high: write suppressed, state and counter cleared.
        OPCODE = 4'b1101;
        repeat (3) tick();
        check("rmid_state", State, 3'd3);
        Reset = 1'b1;
        #1;
        check("rmid_memwrite", MemWrite, 1'b0);
        check("rmid_done", InstrDone, 1'b0);
        tick();
        check("rmid_after_state", State, 3'd0);
        check("rmid_after_count", RetiredCount, 16'd0);
        check("rmid_after_count_w", w_RetiredCount, 4'd0);
        Reset = 1'b0;

        // Counter wrap on the 4-bit instance; the 16-bit instance keeps counting.
        for (int i = 0; i < 15; i++) run_beq();
        check("wrap_pre_state", w_State, 3'd0);
        check("wrap_pre_count_w", w_RetiredCount, 4'd15);
        run_beq();
        check("wrap_count_w", w_RetiredCount, 4'd0);
        check("wrap_count_16", RetiredCount, 16'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 16-bit CPU datapath. Fetches an instruction, decodes the 4-bit OPCODE, and steps the shared ALU, register file and single instruction/data memory through FETCH/DECODE/EXEC/MEM/WB.
- Waits on a memory ready handshake and flags illegal opcodes.
- Counts retired instructions.

Parameters:
- PC_INC, 2, constant selected by AluSrcB=01 (bytes per instruction; informational, the datapath holds the constant)
- CNT_W, 16, width of retired-instruction counter

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high
- OPCODE  input  4  instruction register bits [15:12]; valid from DECODE onward
- MemReady  input  1  memory completes the current read/write this cycle
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IrWrite  output  1  load instruction register
- PcWrite  output  1  unconditional PC load
- PcWriteCond  output  1  PC load if ALU Zero
- PcSource  output  1  0=ALU result, 1=ALUOut (branch target)
- AluSrcA  output  1  0=PC, 1=rs
- AluSrcB  output  2  00=rt, 01=PC_INC, 10=sign-ext imm, 11=sign-ext imm<<1
- AluOp  output  2  00=add, 01=sub, 10=R-funct, 11=immediate-funct
- Shift  output  1  select shifter result
- RegDst  output  1  1=rd, 0=rt
- MemToReg  output  1  1=MDR, 0=ALUOut
- RegWrite  output  1  register file write enable
- Illegal  output  1  one-cycle pulse on undefined opcode
- InstrDone  output  1  one-cycle pulse when an instruction retires
- RetiredCount  output  CNT_W  retired-instruction counter
- State  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4

Behaviour:
- Output decode is combinational from State; IrWrite/PcWrite in FETCH and WB-capable writes in MEM are qualified by MemReady (Mealy).
- Any output not listed for a state is 0.
- Reset:
  - Next edge forces State=FETCH and RetiredCount=0.
  - While Reset=1, all enables are forced 0: MemRead, MemWrite, IrWrite, PcWrite, PcWriteCond, RegWrite, Illegal, InstrDone.
  - Reset mid-instruction abandons it with no register or memory write.
- FETCH:
  - Outputs: IorD=0, MemRead=1, AluSrcA=0, AluSrcB=01, AluOp=00.
  - MemReady=0: hold in FETCH.
  - MemReady=1: IrWrite=1, PcWrite=1, PcSource=0, next state DECODE.
- DECODE:
  - Outputs: AluSrcA=0, AluSrcB=11, AluOp=00 (branch target into ALUOut).
  - Next state is EXEC for legal opcodes 0000, 0001, 0010, 1001, 1010, 1011, 1100, 1101, 1111.
  - Any other opcode: Illegal=1 for this cycle, next state FETCH, no counter increment.
- EXEC, by opcode:
  - 0000/0001: AluSrcA=1, AluSrcB=00, AluOp=10; next WB.
  - 0010: AluSrcA=1, AluOp=10, Shift=1; next WB.
  - 1001/1010/1011: AluSrcA=1, AluSrcB=10, AluOp=11; next WB.
  - 1100/1101: AluSrcA=1, AluSrcB=10, AluOp=00; next MEM.
  - 1111: AluSrcA=1, AluSrcB=00, AluOp=01, PcWriteCond=1, PcSource=1, InstrDone=1; next FETCH.
- MEM:
  - Outputs: IorD=1.
  - LW: MemRead=1; hold until MemReady, then next WB.
  - SW: MemWrite=1 held until MemReady; on MemReady InstrDone=1, next FETCH.
- WB:
  - Outputs: RegWrite=1, InstrDone=1; next FETCH.
  - R-type/shift: RegDst=1, MemToReg=0.
  - I-type: RegDst=0, MemToReg=0.
  - LW: RegDst=0, MemToReg=1.
- Latency (cycles with zero memory wait): R/shift/I-type 4, LW 5, SW 4, BEQ 3. Each MemReady=0 cycle adds 1.
- RetiredCount increments by 1 on every InstrDone and wraps from 2^CNT_W-1 to 0.
- Reset has priority over a simultaneous InstrDone.

Test Plan:
- Reset held 2 cycles, then MemReady=1, OPCODE=0001 -> State sequence 0,1,2,4,0; RegWrite=1 and RegDst=1 only in WB; InstrDone pulses once; RetiredCount=1.
- OPCODE=1100 with MemReady=0 for 3 cycles in MEM -> MemRead and IorD=1 held 4 cycles; WB has MemToReg=1, RegDst=0; total 8 cycles.
- OPCODE=1101, MemReady=1 -> MemWrite=1 for exactly 1 cycle in MEM; RegWrite never asserted; 4 cycles.
- OPCODE=1111 -> EXEC has PcWriteCond=1, PcSource=1, AluOp=01; returns to FETCH after 3 cycles.
- OPCODE=0110 -> Illegal=1 in DECODE only; next state FETCH; RetiredCount unchanged.
- Reset asserted during MEM of a SW -> MemWrite=0 that cycle; State=0 next edge; RetiredCount=0.
- Preload RetiredCount=16'hFFFF via 65535 BEQs -> next retire gives 0.
